date_bcd_encoder: RTL and testbench
===================================

# date_bcd_encoder

Sequential display-side consumer of the watch date counter. Takes the binary day, month and year produced by the date block and converts them into eight BCD digits for the display multiplexer, using an iterative shift-add-3 (double dabble) engine. It re-converts automatically whenever the date changes and flags out-of-range dates.

## Interface
Parameters:
- AUTO_START, 1, 1 means start a conversion whenever the inputs differ from the last snapshot; 0 means start only on `refresh`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- day  in  7  binary day of month, legal range 1..31.
- month  in  7  binary month, legal range 1..12.
- year  in  15  binary year, legal range 0..9999.
- refresh  in  1  single-cycle request to force a conversion.
- y1000, y100, y10, y1  out  4 each  year BCD digits.
- mo10, mo1  out  4 each  month BCD digits.
- d10, d1  out  4 each  day BCD digits.
- busy  out  1  high from the first SHIFT cycle through DONE.
- valid  out  1  one-cycle pulse when the digit outputs update.
- err  out  1  the last converted date was out of range; held until the next DONE.

## Operation
- FSM states are IDLE, LOAD, SHIFT and DONE. The reset state is IDLE.
- IDLE moves to LOAD when `refresh` is high, or when AUTO_START=1 and {day, month, year} differs from the snapshot.
- LOAD:
  - Capture {day, month, year} into the snapshot registers.
  - Compute the range flag: err_n = (year > 9999) | (month == 0) | (month > 12) | (day == 0) | (day > 31).
  - Load the 14-bit shift sources: year[13:0], {7'b0, month}, {7'b0, day}.
  - Clear the BCD accumulators: 16 bits for year, 8 bits each for month and day.
  - Clear the iteration counter.
- SHIFT runs exactly 14 cycles. Each cycle:
  - Add 3 to every accumulator digit that is ≥ 5.
  - Then shift the source MSB into the accumulator LSB.
  - All three fields are processed in parallel.
  - The counter saturates at 13, then the FSM moves to DONE.
- DONE:
  - Write the accumulators to the digit outputs.
  - Write err_n to `err`.
  - Pulse `valid`.
  - Return to IDLE.
- On err_n=1:
  - If year > 9999: y1000..y1 = 4'hF (blank code).
  - If the month is bad: mo10/mo1 = 4'hF.
  - If the day is bad: d10/d1 = 4'hF.
  - Legal fields still show their converted digits.
- Input changes during LOAD, SHIFT or DONE are ignored for the current conversion. The snapshot comparison in the following IDLE cycle triggers a re-conversion.
- `refresh` outside IDLE is dropped; it is not queued.
- A year of 0 converts to 0,0,0,0 with err=0.

## Timing
- Reset values: all digit outputs 0, busy 0, valid 0, err 0, snapshot all-zero, state IDLE.
- Latency, with the trigger sampled at edge T:
  - LOAD occupies T+1.
  - SHIFT runs over T+2..T+15.
  - DONE at T+16, with `valid` high for the cycle after edge T+16.
  - Trigger to valid is 16 cycles.
- Minimum back-to-back trigger spacing is 17 cycles (DONE → IDLE → LOAD).
- Digit outputs change only at the DONE edge and are stable otherwise. There are no glitches between conversions.
- Reset asserted mid-conversion:
  - Immediately returns to reset values; no `valid` is issued.
  - After release, the first IDLE cycle with inputs ≠ 0 starts a conversion.
- When `refresh` and an input change occur in the same IDLE cycle, only one conversion starts.

## Structure
- Package date_pkg holds:
  - YEAR_MAX = 9999, MONTH_MAX = 12, DAY_MAX = 31.
  - N_SHIFT = 14.
  - BLANK_DIGIT = 4'hF.
  - FSM state encoding.
- One sub-module, bcd_add3: combinational 4-bit digit correction (out = in ≥ 5 ? in + 3 : in), instantiated per accumulator digit (8 instances).
- The top module contains the FSM, snapshot/compare, shift registers and output registers.

## Test plan
- Reset release with day=5, month=12, year=2018 → after 16 cycles: 2,0,1,8 / 1,2 / 0,5; one-cycle valid; err=0.
- day=29, month=2, year=9999 → 9,9,9,9 / 0,2 / 2,9; err=0.
- year=10000, month=1, day=1 → y digits F,F,F,F; month 0,1; day 0,1; err=1; valid pulse.
- Year changes 2018→2019 on the 5th SHIFT cycle → first valid shows 2018, then an automatic second conversion; the second valid shows 2019 17 cycles after the first.
- With AUTO_START=0 and unchanged inputs, pulse refresh → valid after 16 cycles with identical digits; an input change without refresh causes no conversion.
- Reset asserted at the 7th SHIFT cycle → all outputs 0, busy 0, no valid; after release a conversion runs and valid arrives 16 cycles after the trigger.

Source files
------------

// File: rtl/date_pkg.sv
// Shared constants, FSM encoding and range-flag type for the date BCD encoder.
package date_pkg;

    localparam logic [14:0] YEAR_MAX    = 15'd9999;
    localparam logic [6:0]  MONTH_MAX   = 7'd12;
    localparam logic [6:0]  DAY_MAX     = 7'd31;
    localparam int unsigned N_SHIFT     = 14;
    localparam logic [3:0]  LAST_SHIFT  = 4'(N_SHIFT - 1);
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
    localparam int unsigned N_DIGITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic year;
        logic month;
        logic day;
    } range_err_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the next shift.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/date_bcd_encoder.sv
// Converts binary day/month/year into eight BCD display digits with a 14-cycle
// shift-add-3 engine; re-converts on date change or refresh and blanks bad fields.
module date_bcd_encoder
    import date_pkg::*;
#(
    parameter bit AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  day,
    input  logic [6:0]  month,
    input  logic [14:0] year,
    input  logic        refresh,
    output logic [3:0]  y1000,
    output logic [3:0]  y100,
    output logic [3:0]  y10,
    output logic [3:0]  y1,
    output logic [3:0]  mo10,
    output logic [3:0]  mo1,
    output logic [3:0]  d10,
    output logic [3:0]  d1,
    output logic        busy,
    output logic        valid,
    output logic        err
);

    state_e      state_q;
    logic [6:0]  day_snap_q, month_snap_q;
    logic [14:0] year_snap_q;
    logic [13:0] yr_src_q, mo_src_q, dy_src_q;
    logic [31:0] acc_q, acc_adj, acc_d;
    logic [31:0] digits_q, digits_d;
    logic [3:0]  cnt_q;
    range_err_t  bad_q, bad_d;
    logic        busy_q, valid_q, err_q;
    logic        start;

    // Accumulator layout: [31:16] year, [15:8] month, [7:0] day.
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    // Shift each field left by one inside its own slice, then insert the source MSBs.
    assign acc_d = ((acc_adj << 1) & 32'hFFFE_FEFE)
                 | {15'd0, yr_src_q[13], 7'd0, mo_src_q[13], 7'd0, dy_src_q[13]};

    assign bad_d.year  = (year > YEAR_MAX);
    assign bad_d.month = (month == 7'd0) || (month > MONTH_MAX);
    assign bad_d.day   = (day == 7'd0) || (day > DAY_MAX);

    assign digits_d = {bad_q.year  ? {4{BLANK_DIGIT}} : acc_q[31:16],
                       bad_q.month ? {2{BLANK_DIGIT}} : acc_q[15:8],
                       bad_q.day   ? {2{BLANK_DIGIT}} : acc_q[7:0]};

    assign start = refresh
                 || (AUTO_START && ({day, month, year} != {day_snap_q, month_snap_q, year_snap_q}));

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            day_snap_q   <= '0;
            month_snap_q <= '0;
            year_snap_q  <= '0;
            yr_src_q     <= '0;
            mo_src_q     <= '0;
            dy_src_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            bad_q        <= '0;
            digits_q     <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    day_snap_q   <= day;
                    month_snap_q <= month;
                    year_snap_q  <= year;
                    bad_q        <= bad_d;
                    yr_src_q     <= year[13:0];
                    mo_src_q     <= {7'd0, month};
                    dy_src_q     <= {7'd0, day};
                    acc_q        <= '0;
                    cnt_q        <= '0;
                    busy_q       <= 1'b1;
                    state_q      <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    acc_q    <= acc_d;
                    yr_src_q <= {yr_src_q[12:0], 1'b0};
                    mo_src_q <= {mo_src_q[12:0], 1'b0};
                    dy_src_q <= {dy_src_q[12:0], 1'b0};
                    if (cnt_q == LAST_SHIFT) state_q <= ST_DONE;
                    else                     cnt_q   <= cnt_q + 4'd1;
                end
                ST_DONE: begin
                    digits_q <= digits_d;
                    err_q    <= |bad_q;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign {y1000, y100, y10, y1, mo10, mo1, d10, d1} = digits_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_date_bcd_encoder.sv
// Randomized and directed bench for date_bcd_encoder against a decimal-arithmetic model.
module tb_date_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  day = '0, month = '0;
    logic [14:0] year = '0;
    logic        refresh = 1'b0;
    logic [3:0]  y1000, y100, y10, y1, mo10, mo1, d10, d1;
    logic        busy, valid, err;

    logic [6:0]  day_m = 7'd3, month_m = 7'd4;
    logic [14:0] year_m = 15'd2024;
    logic        refresh_m = 1'b0;
    logic [3:0]  y1000_m, y100_m, y10_m, y1_m, mo10_m, mo1_m, d10_m, d1_m;
    logic        busy_m, valid_m, err_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    date_bcd_encoder #(.AUTO_START(1'b1)) dut (
        .clk(clk), .rst(rst), .day(day), .month(month), .year(year), .refresh(refresh),
        .y1000(y1000), .y100(y100), .y10(y10), .y1(y1), .mo10(mo10), .mo1(mo1),
        .d10(d10), .d1(d1), .busy(busy), .valid(valid), .err(err)
    );

    date_bcd_encoder #(.AUTO_START(1'b0)) dut_m (
        .clk(clk), .rst(rst), .day(day_m), .month(month_m), .year(year_m), .refresh(refresh_m),
        .y1000(y1000_m), .y100(y100_m), .y10(y10_m), .y1(y1_m), .mo10(mo10_m), .mo1(mo1_m),
        .d10(d10_m), .d1(d1_m), .busy(busy_m), .valid(valid_m), .err(err_m)
    );

    // Expected {8 digits, err} from decimal arithmetic on the date fields.
    function automatic logic [32:0] model(input int d, input int m, input int y);
        bit by = (y > 9999);
        bit bm = (m < 1) || (m > 12);
        bit bd = (d < 1) || (d > 31);
        logic [31:0] v;
        v[31:16] = by ? 16'hFFFF
                      : {4'(y / 1000 % 10), 4'(y / 100 % 10), 4'(y / 10 % 10), 4'(y % 10)};
        v[15:8]  = bm ? 8'hFF : {4'(m / 10 % 10), 4'(m % 10)};
        v[7:0]   = bd ? 8'hFF : {4'(d / 10 % 10), 4'(d % 10)};
        return {v, by | bm | bd};
    endfunction

    function automatic logic [32:0] obs(input bit man);
        if (man) return {y1000_m, y100_m, y10_m, y1_m, mo10_m, mo1_m, d10_m, d1_m, err_m};
        return {y1000, y100, y10, y1, mo10, mo1, d10, d1, err};
    endfunction

    task automatic drive(input int d, input int m, input int y, input bit rf);
        @(negedge clk);
        day = 7'(d); month = 7'(m); year = 15'(y); refresh = rf;
    endtask

    // Counts edges from the trigger edge (edge 1) until valid is seen; -1 on timeout.
    task automatic wait_valid(input bit man, output int n, output logic [63:0] bmask);
        n = -1;
        bmask = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            refresh = 1'b0; refresh_m = 1'b0;
            bmask[i] = man ? busy_m : busy;
            if ((man ? valid_m : valid) === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic count_valids(input bit man, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if ((man ? valid_m : valid) === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset;
        int n;
        logic [63:0] bm;
        day = 7'd5; month = 7'd12; year = 15'd2018;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({obs(0), busy, valid} !== 35'd0) begin
            errors++; $display("FAIL reset_values: got %h want 0", {obs(0), busy, valid});
        end
        @(negedge clk); rst = 1'b1;
        wait_valid(0, n, bm);
        checks++;
        if (n !== 17) begin errors++; $display("FAIL reset_latency: got %0d want 17", n); end
        checks++;
        if (obs(0) !== model(5, 12, 2018)) begin
            errors++; $display("FAIL reset_2018: got %h want %h", obs(0), model(5, 12, 2018));
        end
        checks++;
        if (bm[17:1] !== 17'h0FFFE) begin
            errors++; $display("FAIL busy_window: got %h want 0fffe", bm[17:1]);
        end
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b want 0", valid); end
    endtask

    task automatic test_directed;
        int dv[5] = '{29, 1, 1, 0, 31};
        int mv[5] = '{2, 1, 1, 13, 12};
        int yv[5] = '{9999, 10000, 0, 32767, 16383};
        int n;
        logic [63:0] bm;
        for (int i = 0; i < 5; i++) begin
            drive(dv[i], mv[i], yv[i], 1'b0);
            wait_valid(0, n, bm);
            checks++;
            if (n !== 17) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want 17", i, n); end
            checks++;
            if (obs(0) !== model(dv[i], mv[i], yv[i])) begin
                errors++;
                $display("FAIL directed_digits[%0d]: got %h want %h", i, obs(0), model(dv[i], mv[i], yv[i]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        int n, d, m, y;
        logic [63:0] bm;
        for (int i = 0; i < 24; i++) begin
            d = $urandom_range(0, 40);
            m = $urandom_range(0, 14);
            y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 32767) : $urandom_range(0, 10200);
            drive(d, m, y, 1'b1);
            wait_valid(0, n, bm);
            checks++;
            if (n !== 17 || obs(0) !== model(d, m, y)) begin
                errors++;
                $display("FAIL random[%0d] d=%0d m=%0d y=%0d: got lat %0d %h want lat 17 %h",
                         i, d, m, y, n, obs(0), model(d, m, y));
            end
        end
    endtask

    task automatic test_refresh_and_change;
        int n, cnt;
        logic [63:0] bm;
        drive(17, 8, 1969, 1'b1);
        wait_valid(0, n, bm);
        checks++;
        if (n !== 17 || obs(0) !== model(17, 8, 1969)) begin
            errors++; $display("FAIL refresh_change: got lat %0d %h want lat 17 %h", n, obs(0), model(17, 8, 1969));
        end
        count_valids(0, 25, cnt);
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL refresh_change_single: got %0d extra valids want 0", cnt); end
    endtask

    task automatic test_refresh_dropped;
        int n, cnt;
        drive(7, 7, 2007, 1'b0);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            refresh = (i == 5);
            if (valid === 1'b1) begin n = i; break; end
        end
        refresh = 1'b0;
        checks++;
        if (n !== 17 || obs(0) !== model(7, 7, 2007)) begin
            errors++; $display("FAIL refresh_busy: got lat %0d %h want lat 17 %h", n, obs(0), model(7, 7, 2007));
        end
        count_valids(0, 25, cnt);
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL refresh_dropped: got %0d valids want 0", cnt); end
    endtask

    task automatic test_back_to_back;
        int n, k, glitch;
        logic [32:0] first;
        drive(5, 12, 2018, 1'b0);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 6) year = 15'd2019;
            if (valid === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n !== 17 || obs(0) !== model(5, 12, 2018)) begin
            errors++; $display("FAIL b2b_first: got lat %0d %h want lat 17 %h", n, obs(0), model(5, 12, 2018));
        end
        first = obs(0);
        k = -1; glitch = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) begin k = i; break; end
            if (obs(0) !== first) glitch++;
        end
        checks++;
        if (k !== 17) begin errors++; $display("FAIL b2b_spacing: got %0d want 17", k); end
        checks++;
        if (obs(0) !== model(5, 12, 2019)) begin
            errors++; $display("FAIL b2b_second: got %h want %h", obs(0), model(5, 12, 2019));
        end
        checks++;
        if (glitch !== 0) begin errors++; $display("FAIL b2b_stable: got %0d changes want 0", glitch); end
    endtask

    task automatic test_reset_mid;
        int n, cnt;
        logic [63:0] bm;
        drive(15, 6, 1999, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({obs(0), busy, valid} !== 35'd0) begin
            errors++; $display("FAIL midreset_values: got %h want 0", {obs(0), busy, valid});
        end
        count_valids(0, 12, cnt);
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL midreset_novalid: got %0d want 0", cnt); end
        @(negedge clk); rst = 1'b1;
        wait_valid(0, n, bm);
        checks++;
        if (n !== 17 || obs(0) !== model(15, 6, 1999)) begin
            errors++; $display("FAIL midreset_reconvert: got lat %0d %h want lat 17 %h", n, obs(0), model(15, 6, 1999));
        end
    endtask

    task automatic test_manual;
        int n, cnt;
        logic [63:0] bm;
        count_valids(1, 30, cnt);
        checks++;
        if (cnt !== 0 || obs(1) !== 33'd0) begin
            errors++; $display("FAIL manual_idle: got %0d valids %h want 0 valids 0", cnt, obs(1));
        end
        for (int r = 0; r < 2; r++) begin
            @(negedge clk); refresh_m = 1'b1;
            wait_valid(1, n, bm);
            checks++;
            if (n !== 17 || obs(1) !== model(3, 4, 2024)) begin
                errors++; $display("FAIL manual_refresh[%0d]: got lat %0d %h want lat 17 %h", r, n, obs(1), model(3, 4, 2024));
            end
            @(posedge clk); #1;
        end
        @(negedge clk); day_m = 7'd20;
        count_valids(1, 30, cnt);
        checks++;
        if (cnt !== 0 || obs(1) !== model(3, 4, 2024)) begin
            errors++; $display("FAIL manual_nochange: got %0d valids %h want 0 valids %h", cnt, obs(1), model(3, 4, 2024));
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_refresh_and_change;
        test_refresh_dropped;
        test_back_to_back;
        test_reset_mid;
        test_manual;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
